// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath widths and the writeback trace record.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // One retired register write as captured at the WB stage.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
    logic [XLEN-1:0]       pc4;
  } trace_entry_t;

  localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: register storage, wrapping pointers and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle;
// a pop on an empty FIFO is ignored. Read data is the raw head slot, so the
// caller masks it with !empty_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are not cleared by reset and a push under reset is lost.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_trace_fifo.sv
// Writeback trace buffer: captures qualifying WB-stage register writes into a
// show-ahead FIFO for an external reader, counting all qualifying writes and
// those lost because the FIFO was full.
// Reader handshake: an entry transfers on a rising edge where trace_valid=1 and
// trace_ready=1; trace_ready with trace_valid=0 does nothing; trace_valid never
// depends on trace_ready.
module wb_trace_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter bit SKIP_X0 = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reg_write_wb_in,
  input  logic [REG_ADDR_W-1:0]  write_wb_addr_in,
  input  logic [XLEN-1:0]        final_result_in,
  input  logic [XLEN-1:0]        pc_plus4_wb_in,
  input  logic                   clr_counters,
  input  logic                   trace_ready,
  output logic                   trace_valid,
  output logic [REG_ADDR_W-1:0]  trace_addr,
  output logic [XLEN-1:0]        trace_data,
  output logic [XLEN-1:0]        trace_pc4,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [31:0]            write_count,
  output logic [15:0]            drop_count
);

  trace_entry_t wr_entry;
  trace_entry_t head_entry;
  logic         qualify;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic         drop;
  logic [31:0]  write_count_q, write_count_d;
  logic [15:0]  drop_count_q, drop_count_d;

  assign qualify = reg_write_wb_in && ((write_wb_addr_in != '0) || !SKIP_X0);
  assign pop     = trace_valid && trace_ready;
  assign drop    = qualify && fifo_full && !pop;

  assign wr_entry.addr = write_wb_addr_in;
  assign wr_entry.data = final_result_in;
  assign wr_entry.pc4  = pc_plus4_wb_in;

  sync_fifo #(
    .WIDTH (TRACE_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (qualify),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occupancy)
  );

  // Show-ahead head presentation, forced to zero while nothing is held.
  always_comb begin
    trace_valid = !fifo_empty;
    trace_addr  = '0;
    trace_data  = '0;
    trace_pc4   = '0;
    if (trace_valid) begin
      trace_addr = head_entry.addr;
      trace_data = head_entry.data;
      trace_pc4  = head_entry.pc4;
    end
  end

  // Counter next state: write count wraps, drop count saturates, clear wins.
  always_comb begin
    write_count_d = write_count_q;
    drop_count_d  = drop_count_q;
    if (qualify) write_count_d = write_count_q + 32'd1;
    if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
    if (clr_counters) begin
      write_count_d = '0;
      drop_count_d  = '0;
    end
  end

  // Counter registers; reset overrides clear and any increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      write_count_q <= write_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign write_count = write_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: doc/wb_trace_fifo.md
WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 Parameters SHALL be: DEPTH, 8, FIFO entries (power of two, 2 to 64); SKIP_X0, 1, when 1 writes to x0 are not traced.
REQ-002 One clock, synchronous active-high reset, SHALL be exactly as follows:
clk  in  1  rising-edge clock shared with the 5-stage core
rst  in  1  synchronous, active-high reset
REQ-003 Writeback-side inputs, sampled from the core's WB stage, SHALL be:
reg_write_wb_in  in  1  WB register-write strobe
write_wb_addr_in  in  5  WB destination register
final_result_in  in  32  WB result value
pc_plus4_wb_in  in  32  PC+4 of the retiring instruction
clr_counters  in  1  clears both counters
REQ-004 Reader-side ports SHALL be:
trace_ready  in  1  reader accepts head entry
trace_valid  out  1  head entry available
trace_addr  out  5  head destination register
trace_data  out  32  head result
trace_pc4  out  32  head PC+4
occupancy  out  clog2(DEPTH)+1  entries held
write_count  out  32  qualifying writes seen
drop_count  out  16  qualifying writes lost to full FIFO

Function
REQ-005 A write SHALL qualify when reg_write_wb_in=1 and (write_wb_addr_in!=0 or SKIP_X0=0).
REQ-006 Push SHALL occur on the rising edge where a write qualifies and the FIFO is not full, or is full and a pop occurs in the same cycle.
REQ-007 Pop SHALL occur on the rising edge where trace_valid=1 and trace_ready=1.
REQ-008 Outputs SHALL be show-ahead: trace_addr/data/pc4 present the head entry combinationally from storage while trace_valid=1, and drive 0 while trace_valid=0.
REQ-009 trace_valid SHALL equal (occupancy!=0); no bypass, so an entry pushed at edge N is first visible after edge N, including when pushed into an empty FIFO.
REQ-010 A qualifying write when full with no same-cycle pop SHALL be discarded and drop_count incremented, saturating at 16'hFFFF.
REQ-011 write_count SHALL increment on every qualifying write (pushed or dropped), wrapping modulo 2^32.
REQ-012 Simultaneous push and pop SHALL leave occupancy unchanged and both pointers advance.
REQ-013 Read/write pointers SHALL wrap from DEPTH-1 to 0; occupancy SHALL never exceed DEPTH.
REQ-014 clr_counters=1 SHALL zero write_count and drop_count on that edge, overriding any same-cycle increment; FIFO contents SHALL be unaffected.
REQ-015 trace_ready while trace_valid=0 SHALL have no effect.

Reset
REQ-016 On rst=1 at a rising edge: pointers, occupancy, write_count, drop_count SHALL become 0, trace_valid 0, trace data outputs 0; storage contents need not be cleared.
REQ-017 rst SHALL override any same-cycle push, pop or clr_counters; an entry in flight is lost and not counted.

Structure
REQ-018 XLEN=32 and REG_ADDR_W=5 SHALL come from the shared riscv_pkg package; the trace entry record (addr, data, pc4) SHALL be typedef'd there.
REQ-019 Storage, pointers and occupancy SHALL be one sub-module, sync_fifo, parameterised by width and DEPTH; counters and qualification logic stay in wb_trace_fifo.

Verification
REQ-020 Single write x5=0x0000_00AA, pc4=0x0000_0010, ready=0 -> trace_valid=1 next cycle with those values, occupancy=1, write_count=1.
REQ-021 Write to x0 with SKIP_X0=1 -> no push, write_count stays 0; with SKIP_X0=0 -> pushed, trace_addr=0.
REQ-022 ready=0, 10 consecutive qualifying writes, DEPTH=8 -> occupancy=8, drop_count=2, write_count=10; drained entries are first eight in order.
REQ-023 FIFO full, qualifying write and trace_ready=1 same cycle -> occupancy stays 8, drop_count unchanged, new entry appears at tail.
REQ-024 clr_counters asserted together with a drop -> write_count=0, drop_count=0 after edge; occupancy unchanged.
REQ-025 rst asserted with occupancy=5 and push pending -> next cycle occupancy=0, trace_valid=0, outputs 0, counters 0.
